mkr_button_reader: RTL and testbench

// Input-side counterpart to the LED blink driver: samples one raw MKR header pin (e.g. bMKR_D[5]) wired
// to a push-button and turns it into clean events. Flow: synchronise, debounce, then classify each press
// as short or long. Events go out on a valid/ack handshake to a consumer (SAM interrupt logic, LED logic).

---
 rtl/mkr_button_reader.sv | 184 ++++++++++++++++++
 tb/tb_mkr_button_reader.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mkr_button_reader.sv
// -----------------------------------------------------------------------------
// mkr_button_reader
//
// Turns one raw push-button pin into clean press events. The pin is
// synchronised, debounced and then classified as a short press, a long press
// reaching its threshold, or a release after a long press. Events are held on
// a valid/ack handshake. A sticky overflow flag records an event that was lost
// because the previous one had not been consumed.
//
// Ports
//   iCLK        in   1  single clock for all logic
//   iRESET      in   1  synchronous reset, active-high
//   iBTN        in   1  raw asynchronous button pin
//   oLEVEL      out  1  debounced pressed state (1 = pressed, polarity-free)
//   oEVT_VALID  out  1  an event is pending
//   oEVT_CODE   out  2  01 short press, 10 long press reached, 11 long release
//   iEVT_ACK    in   1  consumer takes the pending event this cycle
//   oOVF        out  1  sticky: an event was dropped while one was pending
// -----------------------------------------------------------------------------
module mkr_button_reader #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 800000,
    parameter int LONG_CYCLES     = 80000000,
    parameter int CNT_W           = 27
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iBTN,
    output logic       oLEVEL,
    output logic       oEVT_VALID,
    output logic [1:0] oEVT_CODE,
    input  logic       iEVT_ACK,
    output logic       oOVF
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_SHORT   = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    // Synchroniser stores the polarity-corrected level, so 0 always means
    // "not pressed" and reset leaves the chain in the released state.
    logic sync_1;
    logic sync_2;
    logic p_sync;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= iBTN ^ ACTIVE_LOW;
            sync_2 <= sync_1;
        end
    end

    assign p_sync = sync_2;

    // Debounce: a new level must persist DEBOUNCE_CYCLES consecutive cycles.
    // The counter never passes DB_LAST, so it cannot wrap.
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            db_cnt <= '0;
            oLEVEL <= 1'b0;
        end else if (p_sync == oLEVEL) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            oLEVEL <= p_sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Edge detection on the debounced level, one cycle after it changes.
    logic level_q;
    logic rise;
    logic fall;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            level_q <= 1'b0;
        end else begin
            level_q <= oLEVEL;
        end
    end

    assign rise = oLEVEL & ~level_q;
    assign fall = ~oLEVEL & level_q;

    // Press classification FSM.
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] dur_cnt;
    logic [CNT_W-1:0] dur_next;
    logic             evt_fire;
    logic [1:0]       evt_new;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state   <= IDLE;
            dur_cnt <= '0;
        end else begin
            state   <= state_next;
            dur_cnt <= dur_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        dur_next   = dur_cnt;
        evt_fire   = 1'b0;
        evt_new    = EVT_NONE;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_next = PRESSED;
                    dur_next   = '0;
                end
            end
            PRESSED: begin
                // A release coinciding with the long threshold counts as short.
                if (fall) begin
                    state_next = IDLE;
                    evt_fire   = 1'b1;
                    evt_new    = EVT_SHORT;
                end else if (dur_cnt == LONG_LAST) begin
                    state_next = LONG;
                    evt_fire   = 1'b1;
                    evt_new    = EVT_LONG;
                end else begin
                    dur_next = dur_cnt + 1'b1;
                end
            end
            LONG: begin
                // dur_cnt holds at the threshold here, so it never wraps.
                if (fall) begin
                    state_next = IDLE;
                    evt_fire   = 1'b1;
                    evt_new    = EVT_RELEASE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Event register and handshake. An ack in the same cycle as a new event
    // frees the slot, so the new event replaces the old one.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oEVT_VALID <= 1'b0;
            oEVT_CODE  <= EVT_NONE;
            oOVF       <= 1'b0;
        end else if (evt_fire) begin
            if (!oEVT_VALID || iEVT_ACK) begin
                oEVT_VALID <= 1'b1;
                oEVT_CODE  <= evt_new;
            end else begin
                oOVF <= 1'b1;
            end
        end else if (oEVT_VALID && iEVT_ACK) begin
            oEVT_VALID <= 1'b0;
            oEVT_CODE  <= EVT_NONE;
        end
    end

endmodule

// File: tb/tb_mkr_button_reader.sv
// -----------------------------------------------------------------------------
// tb_mkr_button_reader
//
// Directed bench for mkr_button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// CNT_W=8. dut drives an active-low button, dut_hi an active-high one.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mkr_button_reader;

    localparam int DB = 4;
    localparam int LC = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       ack;
    logic       level;
    logic       valid;
    logic [1:0] code;
    logic       ovf;

    logic       btn2;
    logic       ack2;
    logic       level2;
    logic       valid2;
    logic [1:0] code2;
    logic       ovf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mkr_button_reader #(
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC),
        .CNT_W          (8)
    ) dut (
        .iCLK      (clk),
        .iRESET    (rst),
        .iBTN      (btn),
        .oLEVEL    (level),
        .oEVT_VALID(valid),
        .oEVT_CODE (code),
        .iEVT_ACK  (ack),
        .oOVF      (ovf)
    );

    mkr_button_reader #(
        .ACTIVE_LOW     (1'b0),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC),
        .CNT_W          (8)
    ) dut_hi (
        .iCLK      (clk),
        .iRESET    (rst),
        .iBTN      (btn2),
        .oLEVEL    (level2),
        .oEVT_VALID(valid2),
        .oEVT_CODE (code2),
        .iEVT_ACK  (ack2),
        .oOVF      (ovf2)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Ticks until dut's valid is high; n = ticks taken, ok = 0 on timeout.
    task automatic wait_valid(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b1;
        while (valid !== 1'b1) begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            tick();
            n++;
        end
    endtask

    // Ticks until dut's level equals want; n = ticks taken, ok = 0 on timeout.
    task automatic wait_level(input logic want, input int budget,
                              output int n, output bit ok);
        n  = 0;
        ok = 1'b1;
        while (level !== want) begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        btn  = 1'b1;
        btn2 = 1'b0;
        ack  = 1'b0;
        ack2 = 1'b0;
        rst  = 1'b1;
        repeat (2) tick();
        checks++;
        if ({level, valid, code, ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000", {level, valid, code, ovf});
        end
        checks++;
        if ({level2, valid2, code2, ovf2} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_hi: got %b want 00000", {level2, valid2, code2, ovf2});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        repeat (20) begin
            tick();
            if (level !== 1'b0 || valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL glitch: level/valid asserted, got 1 want 0");
        end
    endtask

    task automatic test_short();
        int n;
        bit ok;
        bit moved = 1'b0;
        btn = 1'b0;
        repeat (DB + 1) tick();
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL short_level_early: got %b want 0 after 5 edges", level);
        end
        tick();
        checks++;
        if (level !== 1'b1) begin
            errors++;
            $display("FAIL short_level_rise: got %b want 1 after 6 edges", level);
        end
        repeat (4) tick();
        btn = 1'b1;
        // Level falls 6 edges after release; the event lands one edge later.
        wait_valid(20, n, ok);
        checks++;
        if (!ok || n != 7) begin
            errors++;
            $display("FAIL short_valid_latency: got %0d edges (ok=%0b) want 7", n, ok);
        end
        checks++;
        if (code !== 2'b01) begin
            errors++;
            $display("FAIL short_code: got %b want 01", code);
        end
        repeat (50) begin
            tick();
            if (valid !== 1'b1 || code !== 2'b01) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL short_hold: valid/code changed without ack, got %b%b want 101", valid, code);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || code !== 2'b00) begin
            errors++;
            $display("FAIL short_ack: got valid=%b code=%b want 0 00", valid, code);
        end
    endtask

    task automatic test_long_release();
        int n;
        bit ok;
        bit again = 1'b0;
        btn = 1'b0;
        wait_level(1'b1, 20, n, ok);
        // One edge to see the rise, then 20 edges for the duration count.
        wait_valid(40, n, ok);
        checks++;
        if (!ok || n != LC + 1) begin
            errors++;
            $display("FAIL long_latency: got %0d edges (ok=%0b) want %0d", n, ok, LC + 1);
        end
        checks++;
        if (code !== 2'b10) begin
            errors++;
            $display("FAIL long_code: got %b want 10", code);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL long_ack: got valid=%b want 0", valid);
        end
        // 6 + 21 + 1 ticks low so far; stay low to 40.
        repeat (12) begin
            tick();
            if (valid !== 1'b0) again = 1'b1;
        end
        checks++;
        if (again) begin
            errors++;
            $display("FAIL long_once: got a second event while held, want none");
        end
        btn = 1'b1;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || code !== 2'b11) begin
            errors++;
            $display("FAIL long_release_code: got %b (ok=%0b) want 11", code, ok);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL long_release_ack: got valid=%b ovf=%b want 0 0", valid, ovf);
        end
    endtask

    task automatic test_overrun();
        int n;
        bit ok;
        apply_reset();
        btn = 1'b0;
        repeat (40) tick();
        btn = 1'b1;
        repeat (12) tick();
        checks++;
        if (valid !== 1'b1 || code !== 2'b10 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drop: got valid=%b code=%b ovf=%b want 1 10 1", valid, code, ovf);
        end
        apply_reset();
        btn = 1'b0;
        repeat (40) tick();
        btn = 1'b1;
        wait_level(1'b0, 20, n, ok);
        checks++;
        if (!ok || valid !== 1'b1 || code !== 2'b10) begin
            errors++;
            $display("FAIL overrun_pending: got valid=%b code=%b (ok=%0b) want 1 10", valid, code, ok);
        end
        // The fall is acted on at the next edge; ack during that same cycle.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b1 || code !== 2'b11 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL overrun_replace: got valid=%b code=%b ovf=%b want 1 11 0", valid, code, ovf);
        end
    endtask

    task automatic test_reset_mid_press();
        int n;
        bit ok;
        bit seen = 1'b0;
        apply_reset();
        btn = 1'b0;
        wait_level(1'b1, 20, n, ok);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({level, valid, code, ovf} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b want 00000", {level, valid, code, ovf});
        end
        n = 0;
        while (level !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (level !== 1'b1 || n != DB + 2) begin
            errors++;
            $display("FAIL midreset_relevel: got %0d edges level=%b want %0d 1", n, level, DB + 2);
        end
        repeat (10) begin
            tick();
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_event: got valid=1 want 0");
        end
        btn = 1'b1;
        apply_reset();
    endtask

    task automatic test_polarity();
        int n = 0;
        btn2 = 1'b1;
        repeat (DB + 1) tick();
        checks++;
        if (level2 !== 1'b0) begin
            errors++;
            $display("FAIL pol_level_early: got %b want 0", level2);
        end
        tick();
        checks++;
        if (level2 !== 1'b1) begin
            errors++;
            $display("FAIL pol_level_rise: got %b want 1", level2);
        end
        repeat (4) tick();
        btn2 = 1'b0;
        while (valid2 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (valid2 !== 1'b1 || code2 !== 2'b01 || n != 7) begin
            errors++;
            $display("FAIL pol_event: got valid=%b code=%b after %0d want 1 01 after 7", valid2, code2, n);
        end
        ack2 = 1'b1;
        tick();
        ack2 = 1'b0;
        checks++;
        if (valid2 !== 1'b0 || code2 !== 2'b00) begin
            errors++;
            $display("FAIL pol_ack: got valid=%b code=%b want 0 00", valid2, code2);
        end
    endtask

    initial begin
        rst  = 1'b1;
        btn  = 1'b1;
        btn2 = 1'b0;
        ack  = 1'b0;
        ack2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_glitch();
        test_short();
        test_long_release();
        test_overrun();
        test_reset_mid_press();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
